// File: rtl/multi_axis_control.sv
// rtl/multi_axis_control.sv - multi-channel steering/gas/spinner/analog position emulator
module multi_axis_control #(
    parameter int               CHANNELS     = 2,
    parameter int               WIDTH        = 8,
    parameter int               STEP         = 2,
    parameter int               ACCEL_FRAMES = 8,
    parameter logic [WIDTH-1:0] CENTER       = 8'h80,
    parameter logic [WIDTH-1:0] MIN          = 8'h00,
    parameter logic [WIDTH-1:0] MAX          = 8'hFF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      strobe,
    input  logic [2*CHANNELS-1:0]     mode,
    input  logic [CHANNELS-1:0]       plus,
    input  logic [CHANNELS-1:0]       minus,
    input  logic [9*CHANNELS-1:0]     spin_in,
    input  logic [WIDTH*CHANNELS-1:0] analog_in,
    output logic [WIDTH*CHANNELS-1:0] value,
    output logic [CHANNELS-1:0]       changed
);

    // Sums are formed with three guard bits so steps, spinner deltas and
    // analog offsets can never overflow before clamping or wrapping.
    localparam int SW = WIDTH + 3;
    localparam int HW = $clog2(2 * ACCEL_FRAMES + 1);

    localparam logic signed [SW-1:0] CENTER_S = $signed({3'b000, CENTER});
    localparam logic signed [SW-1:0] MIN_S    = $signed({3'b000, MIN});
    localparam logic signed [SW-1:0] MAX_S    = $signed({3'b000, MAX});
    localparam logic signed [SW-1:0] STEP1_S  = SW'(STEP);
    localparam logic signed [SW-1:0] STEP2_S  = SW'(2 * STEP);
    localparam logic signed [SW-1:0] STEP4_S  = SW'(4 * STEP);
    localparam logic [HW-1:0]        HOLD_ACC = HW'(ACCEL_FRAMES);
    localparam logic [HW-1:0]        HOLD_SAT = HW'(2 * ACCEL_FRAMES);

    logic strobe_q;
    logic tick;

    // Frame strobe history, shared by every channel; reset loads the live
    // input so a high strobe at reset release is not seen as an edge.
    always_ff @(posedge clk) begin
        strobe_q <= strobe;
    end

    assign tick = strobe & ~strobe_q;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [1:0]              ch_mode;
        logic                    ch_plus;
        logic                    ch_minus;
        logic [8:0]              ch_spin;
        logic [WIDTH-1:0]        ch_analog;
        logic [WIDTH-1:0]        val_q;
        logic [WIDTH-1:0]        val_next;
        logic                    chg_q;
        logic [HW-1:0]           hold_q;
        logic [HW-1:0]           hold_next;
        logic [1:0]              mode_q;
        logic                    spin_tog_q;
        logic signed [SW-1:0]    val_s;
        logic signed [SW-1:0]    step_s;
        logic signed [SW-1:0]    btn_s;
        logic signed [SW-1:0]    spin_s;
        logic signed [SW-1:0]    diff_s;
        logic signed [SW-1:0]    analog_s;
        logic signed [SW-1:0]    sum_s;

        assign ch_mode   = mode[2*i +: 2];
        assign ch_plus   = plus[i];
        assign ch_minus  = minus[i];
        assign ch_spin   = spin_in[9*i +: 9];
        assign ch_analog = analog_in[WIDTH*i +: WIDTH];

        // Next position and hold count from buttons, tick, spinner and mode.
        always_comb begin
            val_s    = $signed({3'b000, val_q});
            analog_s = $signed({{3{ch_analog[WIDTH-1]}}, ch_analog});
            diff_s   = val_s - CENTER_S;

            if (ch_spin[8] != spin_tog_q) begin
                spin_s = $signed({{(SW-8){ch_spin[7]}}, ch_spin[7:0]});
            end else begin
                spin_s = '0;
            end

            if (hold_q < HOLD_ACC) begin
                step_s = STEP1_S;
            end else if (hold_q < HOLD_SAT) begin
                step_s = STEP2_S;
            end else begin
                step_s = STEP4_S;
            end

            btn_s = '0;
            if (tick) begin
                if (ch_plus && !ch_minus) begin
                    btn_s = step_s;
                end else if (ch_minus && !ch_plus) begin
                    btn_s = -step_s;
                end else if (ch_mode == 2'b01 && !ch_plus && !ch_minus) begin
                    if (diff_s > STEP1_S) begin
                        btn_s = -STEP1_S;
                    end else if (diff_s < -STEP1_S) begin
                        btn_s = STEP1_S;
                    end else begin
                        btn_s = -diff_s;
                    end
                end
            end

            if (ch_mode == 2'b11) begin
                sum_s = CENTER_S + analog_s;
            end else begin
                sum_s = val_s + btn_s + spin_s;
            end

            if (ch_mode == 2'b10) begin
                val_next = sum_s[WIDTH-1:0];
            end else if (sum_s < MIN_S) begin
                val_next = MIN;
            end else if (sum_s > MAX_S) begin
                val_next = MAX;
            end else begin
                val_next = sum_s[WIDTH-1:0];
            end

            if (ch_mode != mode_q || ch_mode == 2'b11) begin
                hold_next = '0;
            end else if (tick) begin
                if (ch_plus ^ ch_minus) begin
                    hold_next = (hold_q == HOLD_SAT) ? hold_q : hold_q + 1'b1;
                end else begin
                    hold_next = '0;
                end
            end else begin
                hold_next = hold_q;
            end
        end

        // Channel state registers; reset re-arms the input history.
        always_ff @(posedge clk) begin
            if (reset) begin
                val_q      <= CENTER;
                chg_q      <= 1'b0;
                hold_q     <= '0;
                mode_q     <= ch_mode;
                spin_tog_q <= ch_spin[8];
            end else begin
                val_q      <= val_next;
                chg_q      <= (val_next != val_q);
                hold_q     <= hold_next;
                mode_q     <= ch_mode;
                spin_tog_q <= ch_spin[8];
            end
        end

        assign value[WIDTH*i +: WIDTH] = val_q;
        assign changed[i]              = chg_q;
    end

endmodule

// File: tb/tb_multi_axis_control.sv
// tb/tb_multi_axis_control.sv - randomized model-checked bench for multi_axis_control
module tb_multi_axis_control;

    localparam int CH = 2;
    localparam int W  = 8;
    localparam int ST = 2;
    localparam int AF = 8;
    localparam int C  = 128;

    logic            clk = 1'b0;
    logic            reset;
    logic            strobe;
    logic [2*CH-1:0] mode;
    logic [CH-1:0]   plus;
    logic [CH-1:0]   minus;
    logic [9*CH-1:0] spin_in;
    logic [W*CH-1:0] analog_in;
    logic [W*CH-1:0] value;
    logic [CH-1:0]   changed;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 0;

    int m_val[CH];
    int m_hold[CH];
    int m_chg[CH];
    int m_mode_prev[CH];
    int m_spin_prev[CH];
    int m_strobe_prev;

    multi_axis_control #(
        .CHANNELS(CH), .WIDTH(W), .STEP(ST), .ACCEL_FRAMES(AF),
        .CENTER(8'h80), .MIN(8'h00), .MAX(8'hFF)
    ) dut (
        .clk(clk), .reset(reset), .strobe(strobe), .mode(mode),
        .plus(plus), .minus(minus), .spin_in(spin_in), .analog_in(analog_in),
        .value(value), .changed(changed)
    );

    always #5 clk = ~clk;

    function automatic int clampi(int v);
        if (v < 0) return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    // Reference model: integer arithmetic straight from the channel rules.
    always @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < CH; c++) begin
                m_val[c]       = C;
                m_chg[c]       = 0;
                m_hold[c]      = 0;
                m_mode_prev[c] = mode[2*c +: 2];
                m_spin_prev[c] = spin_in[9*c+8];
            end
            m_strobe_prev = strobe;
        end else begin
            int t;
            t = (strobe && !m_strobe_prev) ? 1 : 0;
            for (int c = 0; c < CH; c++) begin
                int md, p, mn, s, nv, step, sd, a, nh;
                logic signed [7:0] sd8;
                logic signed [7:0] a8;
                md  = mode[2*c +: 2];
                p   = plus[c];
                mn  = minus[c];
                sd8 = spin_in[9*c +: 8];
                a8  = analog_in[W*c +: W];
                sd  = sd8;
                a   = a8;
                if (md == 3) begin
                    nv = clampi(C + a);
                    nh = 0;
                end else begin
                    step = (m_hold[c] < AF) ? ST : (m_hold[c] < 2*AF) ? 2*ST : 4*ST;
                    s = 0;
                    if (t == 1) begin
                        if (p == 1 && mn == 0) s = step;
                        else if (mn == 1 && p == 0) s = -step;
                        else if (md == 1 && p == 0 && mn == 0) begin
                            if (m_val[c] > C) s = -((m_val[c] - C < ST) ? m_val[c] - C : ST);
                            else s = (C - m_val[c] < ST) ? C - m_val[c] : ST;
                        end
                    end
                    if (spin_in[9*c+8] != m_spin_prev[c]) s += sd;
                    nv = m_val[c] + s;
                    if (md == 2) nv = ((nv % 256) + 256) % 256;
                    else nv = clampi(nv);
                    if (md != m_mode_prev[c]) nh = 0;
                    else if (t == 1) nh = ((p ^ mn) == 1) ? ((m_hold[c] + 1 > 2*AF) ? 2*AF : m_hold[c] + 1) : 0;
                    else nh = m_hold[c];
                end
                m_chg[c]       = (nv != m_val[c]) ? 1 : 0;
                m_val[c]       = nv;
                m_hold[c]      = nh;
                m_mode_prev[c] = md;
                m_spin_prev[c] = spin_in[9*c+8];
            end
            m_strobe_prev = strobe;
        end
    end

    // Compare process: every cycle, just after the active edge.
    always @(posedge clk) begin
        #1;
        if (check_en) begin
            for (int c = 0; c < CH; c++) begin
                logic [7:0] got;
                logic [7:0] exp;
                got = value[W*c +: W];
                exp = 8'(m_val[c]);
                n_checks++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL model_value ch%0d t=%0t got=%02h exp=%02h", c, $time, got, exp);
                end
                n_checks++;
                if (changed[c] !== m_chg[c][0]) begin
                    n_fail++;
                    $display("FAIL model_changed ch%0d t=%0t got=%0b exp=%0d", c, $time, changed[c], m_chg[c]);
                end
            end
        end
    end

    task automatic lit(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%02h exp=%02h", name, got, exp);
        end
    endtask

    task automatic frame_tick(input int n);
        for (int k = 0; k < n; k++) begin
            strobe = 1'b1;
            @(negedge clk);
            strobe = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic spin(input int c, input logic [7:0] d);
        spin_in[9*c +: 8] = d;
        spin_in[9*c+8]    = ~spin_in[9*c+8];
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; strobe = 1'b0; mode = '0; plus = '0; minus = '0;
        spin_in = '0; analog_in = '0;

        // Reset with strobe toggling.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            strobe = ~strobe;
        end
        strobe = 1'b1;
        @(negedge clk);
        lit("reset_val0", value[7:0], 8'h80);
        lit("reset_val1", value[15:8], 8'h80);
        lit("reset_changed", {6'b0, changed}, 8'h00);
        check_en = 1;
        reset = 1'b0;
        @(negedge clk);
        lit("post_reset_no_tick", value[7:0], 8'h80);
        strobe = 1'b0;
        @(negedge clk);

        // Clamp-hold with acceleration on ch0.
        plus[0] = 1'b1;
        frame_tick(8);
        lit("accel_8", value[7:0], 8'h90);
        frame_tick(8);
        lit("accel_16", value[7:0], 8'hB0);
        frame_tick(4);
        lit("accel_20", value[7:0], 8'hD0);
        frame_tick(10);
        lit("saturate", value[7:0], 8'hFF);
        lit("saturate_quiet", {7'b0, changed[0]}, 8'h00);

        // Auto-centre on ch1 from 0x91.
        spin(1, 8'h11);
        lit("ch1_spin_set", value[15:8], 8'h91);
        mode[3:2] = 2'b01;
        @(negedge clk);
        frame_tick(1);
        lit("centre_1", value[15:8], 8'h8F);
        frame_tick(7);
        lit("centre_8", value[15:8], 8'h81);
        frame_tick(1);
        lit("centre_9", value[15:8], 8'h80);
        frame_tick(2);
        lit("centre_rest", value[15:8], 8'h80);
        plus[1] = 1'b1; minus[1] = 1'b1;
        frame_tick(2);
        lit("both_held", value[15:8], 8'h80);
        plus[1] = 1'b0; minus[1] = 1'b0;

        // Wrap mode on ch0.
        plus[0] = 1'b0;
        mode[1:0] = 2'b10;
        @(negedge clk);
        spin(0, 8'hFF);
        lit("wrap_start", value[7:0], 8'hFE);
        plus[0] = 1'b1;
        frame_tick(1);
        plus[0] = 1'b0;
        lit("wrap_over", value[7:0], 8'h00);
        spin(0, 8'h01);
        spin(0, 8'hFD);
        lit("spin_neg", value[7:0], 8'hFE);
        spin(0, 8'h12);
        lit("spin_wrap", value[7:0], 8'h10);
        frame_tick(1);
        spin_in[7:0] = 8'h05;
        spin_in[8]   = ~spin_in[8];
        plus[0] = 1'b1;
        strobe  = 1'b1;
        @(negedge clk);
        strobe  = 1'b0;
        plus[0] = 1'b0;
        lit("spin_plus_tick", value[7:0], 8'h17);
        @(negedge clk);

        // Analog pass-through then auto-centre from the held value.
        mode[1:0] = 2'b11;
        analog_in[7:0] = 8'h7F;
        @(negedge clk);
        lit("analog_7f", value[7:0], 8'hFF);
        analog_in[7:0] = 8'h80;
        @(negedge clk);
        lit("analog_80", value[7:0], 8'h00);
        analog_in[7:0] = 8'h10;
        @(negedge clk);
        lit("analog_10", value[7:0], 8'h90);
        mode[1:0] = 2'b01;
        analog_in[7:0] = 8'h55;
        @(negedge clk);
        frame_tick(1);
        lit("analog_to_centre", value[7:0], 8'h8E);
        frame_tick(7);
        lit("analog_centred", value[7:0], 8'h80);

        // Randomized phase.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            reset = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 2) == 0) strobe = ~strobe;
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 249) == 0) mode[2*c +: 2] = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 24) == 0) plus[c] = ~plus[c];
                if ($urandom_range(0, 24) == 0) minus[c] = ~minus[c];
                if ($urandom_range(0, 9) == 0) begin
                    spin_in[9*c +: 8] = 8'($urandom);
                    spin_in[9*c+8]    = ~spin_in[9*c+8];
                end
                analog_in[W*c +: W] = 8'($urandom);
            end
            @(negedge clk);
        end
        reset = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
